// File: rtl/uart_rx_param_if.sv
// Receive-side output bundle of uart_rx_param: registered word, error flags and
// the valid/ready handshake toward the downstream consumer.
interface uart_rx_param_if #(
  parameter int unsigned DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun;

  modport master (
    output rx_data, rx_valid, frame_err, parity_err, overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, frame_err, parity_err, overrun,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_param.sv
// Divisor-timed UART receiver with 3-sample majority vote and valid/ready output.
// Define UART_RX_PARITY_EN to compile in the PARITY state and parity checker.
module uart_rx_param #(
  parameter int unsigned BAUD_DIV  = 16,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx_pin_in,
  output logic            rx_busy,
  uart_rx_param_if.master rx_if
);

  localparam int unsigned CNT_W = $clog2(BAUD_DIV);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] C_S0   = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] C_S1   = CNT_W'(BAUD_DIV / 2);
  localparam logic [CNT_W-1:0] C_DEC  = CNT_W'(BAUD_DIV / 2 + 1);
  localparam logic [CNT_W-1:0] C_WRAP = CNT_W'(BAUD_DIV - 1);
  localparam logic [IDX_W-1:0] C_LAST = IDX_W'(DATA_BITS - 1);

  if (BAUD_DIV < 8 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY > 2) begin : g_bad_param
    $error("uart_rx_param: illegal BAUD_DIV/DATA_BITS/PARITY");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_e;

  state_e               r_state;
  state_e               w_state_nxt;
  logic                 r_sync1, r_sync2, r_prev;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_s0, r_s1;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_busy;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid, r_frame_err, r_parity_err, r_overrun;

  logic w_fall, w_wrap, w_dec, w_bit;
  logic w_cnt_run, w_shift_en, w_complete;

  assign w_fall = r_prev & ~r_sync2;
  assign w_wrap = (r_cnt == C_WRAP);
  assign w_dec  = (r_cnt == C_DEC);
  // Third vote is the live synchronised line at the decision count
  assign w_bit  = (r_s0 & r_s1) | (r_s0 & r_sync2) | (r_s1 & r_sync2);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_fall) w_state_nxt = S_START;
      S_START: begin
        if (w_dec && w_bit) w_state_nxt = S_IDLE;
        else if (w_wrap)    w_state_nxt = S_DATA;
      end
      S_DATA: begin
        if (w_wrap && (r_idx == C_LAST)) begin
`ifdef UART_RX_PARITY_EN
          w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
`else
          w_state_nxt = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: if (w_wrap) w_state_nxt = S_STOP;
`endif
      // Leave mid-stop so a back-to-back start edge is not missed
      S_STOP:  if (w_dec) w_state_nxt = w_bit ? S_IDLE : S_BREAK;
      S_BREAK: if (r_sync2) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath strobes decoded from the current state
  always_comb begin
    w_cnt_run  = 1'b0;
    w_shift_en = 1'b0;
    w_complete = 1'b0;
    case (r_state)
      S_START:  w_cnt_run = 1'b1;
      S_DATA: begin
        w_cnt_run  = 1'b1;
        w_shift_en = w_dec;
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: w_cnt_run = 1'b1;
`endif
      S_STOP: begin
        w_cnt_run  = 1'b1;
        w_complete = w_dec;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_s0    <= 1'b0;
      r_s1    <= 1'b0;
      r_shift <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_sync1 <= rx_pin_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_busy  <= (w_state_nxt != S_IDLE);
      if (w_cnt_run) r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
      else           r_cnt <= '0;
      if (r_state != S_DATA) r_idx <= '0;
      else if (w_wrap)       r_idx <= r_idx + IDX_W'(1);
      if (r_cnt == C_S0) r_s0 <= r_sync2;
      if (r_cnt == C_S1) r_s1 <= r_sync2;
      if (w_shift_en) r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_par_int;
  logic w_par_exp;

  assign w_par_exp = (PARITY == 1) ? ~(^r_shift) : (^r_shift);

  // Parity verdict for the frame in flight, cleared at each start bit
  always_ff @(posedge clk) begin
    if (rst)                           r_par_int <= 1'b0;
    else if (r_state == S_START)       r_par_int <= 1'b0;
    else if (r_state == S_PARITY && w_dec) r_par_int <= (w_bit != w_par_exp);
  end
`else
  logic r_par_int;
  assign r_par_int = 1'b0;
`endif

  // Output word register and handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_complete) begin
        if (!r_valid || rx_if.rx_ready) begin
          r_data       <= r_shift;
          r_frame_err  <= ~w_bit;
          r_parity_err <= r_par_int;
          r_valid      <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && rx_if.rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_if.rx_data    = r_data;
  assign rx_if.rx_valid   = r_valid;
  assign rx_if.frame_err  = r_frame_err;
  assign rx_if.parity_err = r_parity_err;
  assign rx_if.overrun    = r_overrun;
  assign rx_busy          = r_busy;

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: directed frames push expected words, a
// negedge monitor pops and compares each newly presented word.
module tb_uart_rx_param;

  localparam int BD = 16;
`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int S = 1 + 8 + P;

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       pe;
    int         ec;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pin = 1'b1;
  logic busy;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   vcyc = 0;
  int   ovc = 0;
  exp_t sb[$];

  uart_rx_param_if #(.DATA_BITS(8)) rif ();

  uart_rx_param #(.BAUD_DIV(BD), .DATA_BITS(8), .PARITY(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_pin_in(pin),
    .rx_busy  (busy),
    .rx_if    (rif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one frame; optionally push the word it should produce
  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic sbit,
                            input bit push, input logic pe);
    exp_t e;
    @(negedge clk);
    if (push) begin
      e.d = d; e.fe = ~sbit; e.pe = pe; e.ec = cyc + S * BD + 13;
      sb.push_back(e);
    end
    pin = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      pin = d[i];
      repeat (BD) @(negedge clk);
    end
    if (P == 1) begin
      pin = pbit;
      repeat (BD) @(negedge clk);
    end
    pin = sbit;
    repeat (BD) @(negedge clk);
  endtask

  // Monitor: a new word is valid rising, or valid still high after an accept
  logic pv = 1'b0;
  logic pa = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      pv = 1'b0;
      pa = 1'b0;
    end else begin
      if (rif.rx_valid) vcyc++;
      if (rif.overrun)  ovc++;
      if (rif.rx_valid && (!pv || pa)) begin
        check("word_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("rx_data",    32'(rif.rx_data),    32'(e.d));
          check("frame_err",  32'(rif.frame_err),  32'(e.fe));
          check("parity_err", 32'(rif.parity_err), 32'(e.pe));
          check("valid_time", 32'(cyc),            32'(e.ec));
        end
      end
      pv = rif.rx_valid;
      pa = rif.rx_valid & rif.rx_ready;
    end
  end

  initial begin
    int v0, o0, seen;
    rif.rx_ready = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_data",   32'(rif.rx_data),    32'h0);
    check("rst_valid",  32'(rif.rx_valid),   32'h0);
    check("rst_fe",     32'(rif.frame_err),  32'h0);
    check("rst_pe",     32'(rif.parity_err), 32'h0);
    check("rst_ovr",    32'(rif.overrun),    32'h0);
    check("rst_busy",   32'(busy),           32'h0);

    // Clean 0xA5, even parity bit 0
    rif.rx_ready = 1'b1;
    v0 = vcyc;
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    check("a5_valid_cycles", 32'(vcyc - v0), 32'd1);

    // 0x3C with wrong parity bit
    v0 = vcyc;
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, (P == 1) ? 1'b1 : 1'b0);
    repeat (4) @(negedge clk);
    check("3c_valid_cycles", 32'(vcyc - v0), 32'd1);

    // 0x55 with stop 0, then line held low (break)
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (20 * BD) @(negedge clk);
    check("break_busy", 32'(busy), 32'd1);
    repeat (20 * BD) @(negedge clk);
    pin = 1'b1;
    repeat (6) @(negedge clk);
    check("break_idle", 32'(busy), 32'd0);

    // 4-cycle glitch on an idle line is a false start
    v0 = vcyc;
    seen = 0;
    pin = 1'b0;
    repeat (4) @(negedge clk);
    pin = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy) seen = 1;
    end
    check("glitch_busy_pulse", 32'(seen), 32'd1);
    check("glitch_no_word",    32'(vcyc - v0), 32'd0);

    // Overrun: 0x11 held, 0x22 dropped
    rif.rx_ready = 1'b0;
    o0 = ovc;
    send_frame(8'h11, 1'b0, 1'b1, 1'b1, 1'b0);
    send_frame(8'h22, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    check("ovr_pulses",     32'(ovc - o0),       32'd1);
    check("ovr_data_held",  32'(rif.rx_data),    32'h11);
    check("ovr_valid_held", 32'(rif.rx_valid),   32'd1);
    rif.rx_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("ovr_accepted",   32'(rif.rx_valid),   32'd0);

    // Reset during data bit 4; bits 3..7, parity and stop are 1 so no spurious edge
    fork
      send_frame(8'hF8, 1'b1, 1'b1, 1'b0, 1'b0);
      begin
        repeat (5 * BD + 9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_data",  32'(rif.rx_data),    32'h0);
        check("mid_rst_valid", 32'(rif.rx_valid),   32'h0);
        check("mid_rst_fe",    32'(rif.frame_err),  32'h0);
        check("mid_rst_pe",    32'(rif.parity_err), 32'h0);
        check("mid_rst_ovr",   32'(rif.overrun),    32'h0);
        check("mid_rst_busy",  32'(busy),           32'h0);
      end
    join
    repeat (10) @(negedge clk);
    send_frame(8'h7E, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver for the serial-receive path: an oversampling-free, divisor-timed receiver that supports configurable data width, optional parity and majority-vote mid-bit sampling. It reports framing, parity and overrun errors alongside a valid/ready output handshake. The input is resynchronised internally. The block is the next-generation drop-in for the fixed 8-bit receive top and feeds the same downstream consumers through a registered data word.

## Interface
- BAUD_DIV, 16: clock cycles per bit; legal range ≥ 8.
- DATA_BITS, 8: data bits per frame, 5..9, sent LSB first.
- PARITY, 0: 0 = none, 1 = odd, 2 = even. Only meaningful with UART_RX_PARITY_EN.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- rx_pin_in  in  1  asynchronous serial line; idle high.
- rx_data  out  DATA_BITS  received word; valid while rx_valid = 1.
- rx_valid  out  1  word available; held until accepted.
- rx_ready  in  1  consumer accepts the word when rx_valid & rx_ready.
- frame_err  out  1  stop bit sampled 0; qualified by rx_valid.
- parity_err  out  1  parity mismatch; qualified by rx_valid.
- overrun  out  1  one-cycle pulse; a completed frame was dropped.
- rx_busy  out  1  high in every state except IDLE.

## Operation
- Input: 2-flop synchroniser, reset to 1. Falling-edge detect is done on the synchronised signal versus its previous value.
- Bit timer: cnt runs 0..BAUD_DIV-1 and wraps; bit index increments on wrap.
- Sampling: the line is captured at cnt = BAUD_DIV/2-1, BAUD_DIV/2 and BAUD_DIV/2+1. Bit value = majority of 3, decided at cnt = BAUD_DIV/2+1.
- FSM states:
  - IDLE: a synchronised falling edge moves to START with cnt=0.
  - START: if the decided value is 1, it is a false start and the FSM returns to IDLE. If 0, it continues; on wrap it moves to DATA.
  - DATA: shifts the decided bit into the shift register MSB side (LSB-first assembly). After DATA_BITS bits it moves to PARITY if enabled, otherwise to STOP.
  - PARITY: compares the received bit to the XOR of data (odd: expect ~XOR; even: expect XOR) and latches parity_err_int. On wrap it moves to STOP.
  - STOP: at the decision point, loads the output register, then:
    - stop bit = 1: go to IDLE immediately (mid-stop), so back-to-back frames are caught.
    - stop bit = 0: set frame_err and go to BREAK.
  - BREAK: wait for a synchronised 1, then go to IDLE. A held-low line produces no further frames.
- Output register: on frame completion:
  - if !rx_valid, or rx_valid & rx_ready in the same cycle, load rx_data, frame_err and parity_err, and set rx_valid=1;
  - otherwise keep the old word and pulse overrun for 1 cycle.
- rx_valid clears on rx_valid & rx_ready with no simultaneous completion.
- rst has priority over everything, including mid-frame. FSM → IDLE, counters 0, shift register 0.

## Timing
- Reset values: rx_data=0, rx_valid=0, frame_err=0, parity_err=0, overrun=0, rx_busy=0, synchroniser=1.
- Edge latency: a pin fall is seen as the edge T = pin edge + 2 cycles (synchroniser) + 1 cycle (edge register).
- Bit k (start = 0) is decided at cycle T + k·BAUD_DIV + BAUD_DIV/2 + 1.
- Stop index S = 1 + DATA_BITS + P, where P = 1 if parity is enabled and PARITY≠0, else 0. rx_valid rises at T + S·BAUD_DIV + BAUD_DIV/2 + 2.
- Throughput: one word per frame. The consumer must accept within one frame time to avoid overrun.

## Configuration
- UART_RX_PARITY_EN defined: the PARITY state and checker are compiled in, and PARITY selects none/odd/even.
- Not defined: the PARITY state is removed, the frame is start + DATA_BITS + stop regardless of PARITY, and parity_err is tied 0.

## Test plan
(BAUD_DIV=16, DATA_BITS=8, UART_RX_PARITY_EN defined, PARITY=2; T as defined under Timing)
- Send 0xA5 with even parity bit 0 and stop 1, rx_ready=1. Required: rx_data=0xA5, rx_valid at T+170 for one cycle, frame_err=0, parity_err=0.
- Send 0x3C with parity bit 1 (wrong). Required: rx_data=0x3C, parity_err=1, frame_err=0.
- Send 0x55 with stop bit 0, then hold the line low for 40 bit times, then go high. Required: one word with frame_err=1, no further rx_valid while low, rx_busy=0 after the line returns high.
- Apply a 4-cycle low glitch on an idle line. Required: rx_busy pulses, and rx_valid stays 0.
- With rx_ready=0, send 0x11 then 0x22 back-to-back. Required: rx_data stays 0x11 and overrun pulses exactly 1 cycle. Then raise rx_ready: the word is accepted and rx_valid goes to 0.
- Assert rst for 1 cycle during data bit 4, then send 0x7E. Required: all outputs 0 after reset, no partial word, and the next word is rx_data=0x7E.
